// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the 16-bit MIPS multicycle control unit.
// Holds the FSM state codes, opcode constants, ALU select codes, datapath
// mux select constants and the packed control word produced by the output
// decoder. No ports.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ADDI  = 3'd1;
  localparam logic [2:0] OP_J     = 3'd2;
  localparam logic [2:0] OP_RSVD  = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_BNE   = 3'd5;
  localparam logic [2:0] OP_LW    = 3'd6;
  localparam logic [2:0] OP_SW    = 3'd7;

  // Highest legal R-type funct; anything above it halts the machine.
  localparam logic [3:0] FUNCT_MAX = 4'd4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_REG = 1'b1;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_TWO     = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH1 = 2'd3;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_select;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       halted;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bus between the multicycle controller and the datapath.
// Datapath -> controller: opcode (IR[15:13]), funct (IR[3:0]), zero_result.
// Controller -> datapath: every mux select and write enable.
// master: the controller side; slave: the datapath side.
interface mips_multicycle_ctrl_if;
  logic [2:0] opcode;
  logic [3:0] funct;
  logic       zero_result;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_select;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       mem_read;
  logic       mem_write;

  modport master (
    input  opcode, funct, zero_result,
    output ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_select,
           reg_write, reg_dst, mem_to_reg, mem_read, mem_write
  );

  modport slave (
    output opcode, funct, zero_result,
    input  ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_select,
           reg_write, reg_dst, mem_to_reg, mem_read, mem_write
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Purely combinational output decoder for the multicycle controller.
// Inputs : state (registered FSM state), opcode, funct, zero_result.
// Outputs: ctrl, the full control word (mux selects, write enables,
//          halted and retire). Every field defaults to 0.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] opcode,
  input  logic [3:0] funct,
  input  logic       zero_result,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_SRC_ALU;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_TWO;
        ctrl.alu_select = ALU_ADD;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_IMM_SH1;
        ctrl.alu_select = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a  = SRC_A_REG;
        ctrl.alu_src_b  = SRC_B_REG;
        ctrl.alu_select = funct[2:0];
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a  = SRC_A_REG;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_select = ALU_ADD;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_MEM_RD: ctrl.mem_read = 1'b1;
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        // The only Mealy output: branch taken follows the live zero flag.
        ctrl.alu_src_a  = SRC_A_REG;
        ctrl.alu_src_b  = SRC_B_REG;
        ctrl.alu_select = ALU_SUB;
        ctrl.pc_src     = PC_SRC_ALUOUT;
        ctrl.pc_write   = (opcode == OP_BNE) ? ~zero_result : zero_result;
        ctrl.retire     = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_SRC_JUMP;
        ctrl.pc_write = 1'b1;
        ctrl.retire   = 1'b1;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control unit for the 16-bit MIPS datapath.
// Ports: clock, n_reset (async, active-low), run (execute / pause at the
// next instruction boundary), dp (datapath control bus, master side),
// halted, retire (pulse in each instruction's last state), instr_count
// (retired instructions, wraps), state (current state code for debug).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic                  run,
  mips_multicycle_ctrl_if.master dp,
  output logic                  halted,
  output logic                  retire,
  output logic [15:0]           instr_count,
  output logic [3:0]            state
);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] count_reg;
  ctrl_t       ctrl;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)        count_reg <= 16'd0;
    else if (ctrl.retire) count_reg <= count_reg + 16'd1;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        unique case (dp.opcode)
          OP_RTYPE:      state_next = (dp.funct > FUNCT_MAX) ? S_HALT : S_EXEC_R;
          OP_ADDI:       state_next = S_EXEC_I;
          OP_J:          state_next = S_JUMP;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          default:       state_next = S_HALT;
        endcase
      end
      S_EXEC_R:   state_next = S_WB_R;
      S_EXEC_I:   state_next = S_WB_I;
      S_MEM_ADDR: state_next = (dp.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_next = S_WB_MEM;
      // run is only looked at on instruction boundaries.
      S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP:
        state_next = run ? S_FETCH : S_IDLE;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state       (state_reg),
    .opcode      (dp.opcode),
    .funct       (dp.funct),
    .zero_result (dp.zero_result),
    .ctrl        (ctrl)
  );

  assign dp.ir_write   = ctrl.ir_write;
  assign dp.pc_write   = ctrl.pc_write;
  assign dp.pc_src     = ctrl.pc_src;
  assign dp.alu_src_a  = ctrl.alu_src_a;
  assign dp.alu_src_b  = ctrl.alu_src_b;
  assign dp.alu_select = ctrl.alu_select;
  assign dp.reg_write  = ctrl.reg_write;
  assign dp.reg_dst    = ctrl.reg_dst;
  assign dp.mem_to_reg = ctrl.mem_to_reg;
  assign dp.mem_read   = ctrl.mem_read;
  assign dp.mem_write  = ctrl.mem_write;

  assign halted      = ctrl.halted;
  assign retire      = ctrl.retire;
  assign instr_count = count_reg;
  assign state       = state_reg;

endmodule
